// File: rtl/m_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The entry record is {pc, fq_meta_t}; pc width is a module parameter, so it is kept outside the struct.
package m_fetch_queue_pkg;

  localparam logic [31:0] FQ_NOP = 32'h0000_0020;

  typedef struct packed {
    logic        pr;
    logic [31:0] ir;
  } fq_meta_t;

  function automatic int unsigned fq_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/m_fq_storage.sv
// Fetch queue entry array: synchronous write, asynchronous read at the head pointer, no reset.
module m_fq_storage
  import m_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 11,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  logic [AW-1:0] wpc_i,
  input  fq_meta_t      wmeta_i,
  input  logic [PW-1:0] raddr_i,
  output logic [AW-1:0] rpc_o,
  output fq_meta_t      rmeta_o
);

  logic [AW-1:0] pc_q   [DEPTH];
  fq_meta_t      meta_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      pc_q[waddr_i]   <= wpc_i;
      meta_q[waddr_i] <= wmeta_i;
    end
  end

  assign rpc_o   = pc_q[raddr_i];
  assign rmeta_o = meta_q[raddr_i];

endmodule

// File: rtl/m_fetch_queue.sv
// Instruction fetch queue between IF and ID: circular buffer, flush on mispredict, NOP when empty.
// Optional same-cycle bypass of an empty queue: define FETCH_QUEUE_BYPASS_EN.
module m_fetch_queue
  import m_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 11
) (
  input  logic                        w_clk,
  input  logic                        w_rst_n,
  input  logic                        w_in_valid,
  output logic                        w_in_ready,
  input  logic [AW-1:0]               w_in_pc,
  input  logic [31:0]                 w_in_ir,
  input  logic                        w_in_pr,
  output logic                        r_out_valid,
  input  logic                        w_out_ready,
  output logic [AW-1:0]               w_out_pc,
  output logic [AW-1:0]               w_out_pc4,
  output logic [31:0]                 w_out_ir,
  output logic                        w_out_pr,
  input  logic                        w_flush,
  output logic [fq_cnt_w(DEPTH)-1:0]  r_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = fq_cnt_w(DEPTH);

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty, full, byp, pass, pop, push, do_push, do_pop;
  logic [AW-1:0] rd_pc, out_pc;
  fq_meta_t      rd_meta, out_meta, in_meta;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign in_meta = '{pr: w_in_pr, ir: w_in_ir};

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = empty && w_in_valid && !w_flush;
`else
  assign byp = 1'b0;
`endif

  assign r_out_valid = !empty || byp;
  assign pop         = r_out_valid && w_out_ready;
  assign w_in_ready  = !full || pop;
  assign push        = w_in_valid && w_in_ready;
  // A bypassed entry consumed in the same cycle never touches the array or the count.
  assign pass        = byp && w_out_ready;
  assign do_push     = push && !pass;
  assign do_pop      = pop && !empty;

  always_comb begin
    head_d  = head_q + PW'(do_pop);
    tail_d  = tail_q + PW'(do_push);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    if (w_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  m_fq_storage #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .PW    (PW)
  ) u_storage (
    .clk_i   (w_clk),
    .we_i    (do_push && !w_flush),
    .waddr_i (tail_q),
    .wpc_i   (w_in_pc),
    .wmeta_i (in_meta),
    .raddr_i (head_q),
    .rpc_o   (rd_pc),
    .rmeta_o (rd_meta)
  );

  always_comb begin
    out_pc   = rd_pc;
    out_meta = rd_meta;
    if (byp) begin
      out_pc   = w_in_pc;
      out_meta = in_meta;
    end else if (empty) begin
      out_pc   = '0;
      out_meta = '{pr: 1'b0, ir: FQ_NOP};
    end
  end

  assign w_out_pc  = out_pc;
  assign w_out_pc4 = r_out_valid ? out_pc + AW'(1) : '0;
  assign w_out_ir  = out_meta.ir;
  assign w_out_pr  = out_meta.pr;
  assign r_count   = count_q;

endmodule

// File: tb/tb_m_fetch_queue.sv
// Scoreboard bench for m_fetch_queue: expected entries queued on accepted push, compared on pop.
module tb_m_fetch_queue;
  import m_fetch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 11;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] pc;
    logic          pr;
    logic [31:0]   ir;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_pr, out_valid, out_ready, out_pr, flush;
  logic [AW-1:0] in_pc, out_pc, out_pc4;
  logic [31:0]   in_ir, out_ir;
  logic [2:0]    count;

  int   checks = 0;
  int   errors = 0;
  ent_t sb_q[$];

  always #5 clk = ~clk;

  m_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .w_clk       (clk),
    .w_rst_n     (rst_n),
    .w_in_valid  (in_valid),
    .w_in_ready  (in_ready),
    .w_in_pc     (in_pc),
    .w_in_ir     (in_ir),
    .w_in_pr     (in_pr),
    .r_out_valid (out_valid),
    .w_out_ready (out_ready),
    .w_out_pc    (out_pc),
    .w_out_pc4   (out_pc4),
    .w_out_ir    (out_ir),
    .w_out_pr    (out_pr),
    .w_flush     (flush),
    .r_count     (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs();
    check("count", 32'(count), 32'd0);
    check("valid", 32'(out_valid), 32'd0);
    check("ready", 32'(in_ready), 32'd1);
    check("nop_ir", out_ir, FQ_NOP);
    check("nop_pc", 32'(out_pc), 32'd0);
    check("nop_pc4", 32'(out_pc4), 32'd0);
    check("nop_pr", 32'(out_pr), 32'd0);
  endtask

  // One clock cycle: drive, check against the queue model just before the edge, then update it.
  task automatic step(input logic v, input logic [AW-1:0] pc, input logic pr,
                      input logic ordy, input logic fl);
    int            n;
    logic          byp, mvalid, mready, mpush, mpop;
    logic [AW-1:0] p4;
    ent_t          e, h;
    e = '{pc: pc, pr: pr, ir: 32'h8C01_0000 + 32'(pc)};
    in_valid = v; in_pc = pc; in_ir = e.ir; in_pr = pr; out_ready = ordy; flush = fl;
    #1;
    n      = sb_q.size();
    byp    = BYP && n == 0 && v && !fl;
    mvalid = n > 0 || byp;
    mready = n < int'(DEPTH) || (mvalid && ordy);
    h      = (n > 0) ? sb_q[0] : e;
    check("count", 32'(count), 32'(n));
    check("valid", 32'(out_valid), 32'(mvalid));
    check("ready", 32'(in_ready), 32'(mready));
    if (mvalid) begin
      p4 = h.pc + AW'(1);
      check("head_pc", 32'(out_pc), 32'(h.pc));
      check("head_pc4", 32'(out_pc4), 32'(p4));
      check("head_ir", out_ir, h.ir);
      check("head_pr", 32'(out_pr), 32'(h.pr));
    end else begin
      check("nop_ir", out_ir, FQ_NOP);
      check("nop_pc", 32'(out_pc), 32'd0);
      check("nop_pc4", 32'(out_pc4), 32'd0);
      check("nop_pr", 32'(out_pr), 32'd0);
    end
    mpush = v && mready;
    mpop  = mvalid && ordy;
    @(posedge clk);
    if (fl) sb_q.delete();
    else begin
      if (mpush) sb_q.push_back(e);
      if (mpop) void'(sb_q.pop_front());
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_ir = '0; in_pr = 1'b0;
    out_ready = 1'b0; flush = 1'b0;
    #12;
    check_idle_outputs();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Fill with ID stalled, confirm full, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, AW'(i), i[0], 1'b0, 1'b0);
    step(1'b1, AW'(99), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Refill, then matched push+pop at full across pointer wrap.
    for (int i = 0; i < 4; i++) step(1'b1, AW'(i), i[1], 1'b0, 1'b0);
    for (int i = 4; i < 21; i++) step(1'b1, AW'(i), i[0], 1'b1, 1'b0);

    // Pop to three, flush with a concurrent push, then a fresh push.
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b1, AW'(9), 1'b1, 1'b1, 1'b1);
    step(1'b1, AW'('h12), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Stall with a steady push stream, then release and drain.
    for (int i = 0; i < 5; i++) step(1'b1, AW'('h20 + i), i[0], 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Empty queue, push at the top PC with pr set and ID ready (pc4 wraps).
    step(1'b1, AW'('h7FF), 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 3; i++) step(1'b1, AW'('h40 + i), 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs();
    sb_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, AW'('h55), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_fetch_queue.md
# m_fetch_queue

Instruction fetch queue between the IF-stage instruction memory and the ID stage of the 5-stage processor. Buffers up to DEPTH fetched instructions with their PC and branch-prediction bit, so fetch keeps running while ID/EX are held by a load-use interlock. On a branch mispredict it discards every buffered instruction. When it holds nothing to issue it presents a NOP to decode.

## Interface

Parameters:
- DEPTH, 4: number of entries; power of two, 2..16.
- AW, 11: PC width in words.

Ports:
- w_clk  in  1  clock; all state changes on posedge.
- w_rst_n  in  1  reset, asynchronous, active-low.
- w_in_valid  in  1  IF presents a fetched instruction this cycle.
- w_in_ready  out  1  queue accepts the push this cycle.
- w_in_pc  in  AW  PC of the pushed instruction.
- w_in_ir  in  32  pushed instruction word.
- w_in_pr  in  1  predictor said taken for this PC (w_pre && w_pr).
- r_out_valid  out  1  head entry is valid.
- w_out_ready  in  1  ID consumes the head (driven by !w_interlock).
- w_out_pc  out  AW  head PC.
- w_out_pc4  out  AW  head PC + 1, wrapping modulo 2^AW.
- w_out_ir  out  32  head instruction; 32'h20 (NOP) when r_out_valid = 0.
- w_out_pr  out  1  head prediction bit; 0 when not valid.
- w_flush  in  1  mispredict (w_pr_fail); empties the queue.
- r_count  out  $clog2(DEPTH)+1  occupancy.

## Operation

- Circular buffer with head and tail pointers of $clog2(DEPTH) bits each; pointers wrap modulo DEPTH.
- Push fires when w_in_valid && w_in_ready. Pop fires when r_out_valid && w_out_ready.
- w_in_ready = (r_count < DEPTH) || pop, so a simultaneous push and pop at full is accepted.
- r_count next value:
  - +1 on push only.
  - −1 on pop only.
  - unchanged on push+pop.
- Empty (r_count = 0):
  - r_out_valid = 0.
  - Outputs show NOP, pc 0, pc4 0, pr 0.
  - w_out_ready is ignored.
- Flush has priority over push and pop:
  - Next state is r_count = 0 and head = tail = 0.
  - A push presented in the flush cycle is dropped.
  - A pop presented in the flush cycle is not counted.
  - Stored entries are not cleared; they are masked by count.
- w_out_pr is carried unchanged from w_in_pr. The queue never alters a prediction.
- Reset asserted at any time, including mid-burst, returns the block to the empty state immediately. Asynchronous assert, synchronous release.
- Reset values:
  - r_out_valid 0, r_count 0, w_in_ready 1.
  - w_out_ir 32'h20, w_out_pc 0, w_out_pc4 0, w_out_pr 0.

## Timing

- Push→visible latency: an entry pushed at edge N is at the head from N+1 when the queue was empty. Minimum one cycle, unless the bypass below is compiled in.
- Output fields are combinational reads of the registered head entry. No path runs from w_in_* to w_out_* without the bypass.
- The w_in_ready dependency on w_out_ready is the only same-cycle in→out combinational path.
- Flush asserted in cycle N: r_out_valid = 0 from N+1. The first post-flush push is at the head from N+2.
- Throughput: one push and one pop per cycle sustained.

## Configuration

- FETCH_QUEUE_BYPASS_EN defined:
  - Applies when the queue is empty, w_in_valid = 1 and w_flush = 0.
  - w_out_* and r_out_valid reflect w_in_* combinationally in the same cycle.
  - If w_out_ready is also 1, the instruction passes straight through and is not written; r_count stays 0.
  - Otherwise it is written as a normal push.
- Undefined: no bypass path; the minimum latency is one cycle.

## Structure

- Shared package holds:
  - the NOP constant 32'h20;
  - the entry record {pc[AW-1:0], pr, ir[31:0]};
  - the occupancy width function.
- One sub-module, m_fq_storage:
  - DEPTH × entry register array;
  - synchronous write port, asynchronous read port at the head pointer;
  - no reset on the array.
- Pointer, count, flush and bypass logic live in m_fetch_queue.

## Test plan

- Reset then idle: r_count 0, r_out_valid 0, w_out_ir 32'h20, w_in_ready 1. Release reset and hold for 3 cycles; outputs unchanged.
- Fill with w_out_ready = 0: push pc 0..3 with ir 32'h8C010000+pc. After 4 pushes r_count = 4 and w_in_ready = 0. Raise w_out_ready: pops return pc 0,1,2,3 in order with pc4 1,2,3,4.
- Full push+pop: at r_count = 4 assert push (pc 4) and pop together. Push is accepted, r_count stays 4, head advances to pc 1. After 16 more matched cycles the pointers have wrapped and order is preserved.
- Flush mid-stream: r_count = 3, assert w_flush together with push pc 9. Next cycle r_count 0 and r_out_valid 0; pc 9 never appears. A push of pc 0x12 the following cycle is at the head with pr as pushed.
- Stall: hold w_out_ready = 0 for 5 cycles with a steady push stream. The head stays fixed, r_count saturates at 4, and no entry is lost or duplicated after release.
- Bypass (FETCH_QUEUE_BYPASS_EN defined): empty queue, push pc 0x7FF with pr 1 and w_out_ready 1. Same cycle: r_out_valid 1, pc 0x7FF, pc4 0x000, pr 1. r_count remains 0. Without the macro, r_out_valid rises one cycle later.
